// File: rtl/ps2_device_port.sv
// rtl/ps2_device_port.sv - device-side PS/2 port: clock generation, device->host TX, host->device RX with ack
// Optional resend-on-0xFE and retry-after-inhibit: define PS2_DEV_RESEND_EN.
module ps2_device_port #(
  parameter int HALF_CYC = 2000,
  parameter int IDLE_CYC = 5000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_ps2_clk_e,
  output logic       o_ps2_data_e,
  input  logic       i_tx_val,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_ready,
  output logic       o_tx_done,
  output logic       o_tx_abort,
  output logic       o_rx_val,
  output logic [7:0] o_rx_data,
  output logic       o_rx_err
);

  localparam int PW = $clog2(2 * HALF_CYC) + 1;
  localparam int IW = $clog2(IDLE_CYC + 1) + 1;
  localparam logic [PW-1:0] P_Q  = PW'(HALF_CYC / 2 - 1);
  localparam logic [PW-1:0] P_H  = PW'(HALF_CYC - 1);
  localparam logic [PW-1:0] P_S  = PW'(HALF_CYC + HALF_CYC / 2);
  localparam logic [PW-1:0] P_3Q = PW'(HALF_CYC + HALF_CYC / 2 - 1);
  localparam logic [PW-1:0] P_2H = PW'(2 * HALF_CYC - 1);
  localparam logic [IW-1:0] I_MAX = IW'(IDLE_CYC);

  typedef enum logic [2:0] {
    S_IDLE, S_TX_BIT, S_RX_START, S_RX_BIT, S_RX_ACK, S_WAIT_IDLE
  } state_t;

  state_t          r_state, w_state_n;
  logic            r_clk_s1, r_sclk, r_dat_s1, r_sdat;
  logic [IW-1:0]   r_idle_cnt;
  logic [PW-1:0]   r_phase, w_phase_n;
  logic [3:0]      r_bit, w_bit_n;
  logic            r_pending, w_pending_n;
  logic [7:0]      r_tx_byte, w_tx_byte_n;
  logic [9:0]      r_tx_frame, w_tx_frame_n;
  logic [9:0]      r_rx_shift, w_rx_shift_n;
  logic            r_clk_e, w_clk_e_n;
  logic            r_data_e, w_data_e_n;
  logic            r_tx_done, w_tx_done_n;
  logic            r_tx_abort, w_tx_abort_n;
  logic            r_rx_val, w_rx_val_n;
  logic [7:0]      r_rx_data, w_rx_data_n;
  logic            r_rx_err, w_rx_err_n;
  logic            w_par_ok;
  logic            w_resend_req;
`ifdef PS2_DEV_RESEND_EN
  logic [7:0]      r_last_byte, w_last_byte_n;
  logic            r_last_val, w_last_val_n;
`endif

  assign w_par_ok = ^r_rx_shift[8:0];
`ifdef PS2_DEV_RESEND_EN
  assign w_resend_req = (r_rx_shift[7:0] == 8'hFE) && w_par_ok;
`else
  assign w_resend_req = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_clk_s1   <= 1'b1;
      r_sclk     <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_sdat     <= 1'b1;
      r_idle_cnt <= '0;
    end else begin
      r_clk_s1 <= i_ps2_clk;
      r_sclk   <= r_clk_s1;
      r_dat_s1 <= i_ps2_data;
      r_sdat   <= r_dat_s1;
      if (!r_sclk || !r_sdat)     r_idle_cnt <= '0;
      else if (r_idle_cnt != I_MAX) r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_phase    <= '0;
      r_bit      <= '0;
      r_pending  <= 1'b0;
      r_tx_byte  <= '0;
      r_tx_frame <= '0;
      r_rx_shift <= '0;
      r_clk_e    <= 1'b0;
      r_data_e   <= 1'b0;
      r_tx_done  <= 1'b0;
      r_tx_abort <= 1'b0;
      r_rx_val   <= 1'b0;
      r_rx_data  <= '0;
      r_rx_err   <= 1'b0;
`ifdef PS2_DEV_RESEND_EN
      r_last_byte <= '0;
      r_last_val  <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_n;
      r_phase    <= w_phase_n;
      r_bit      <= w_bit_n;
      r_pending  <= w_pending_n;
      r_tx_byte  <= w_tx_byte_n;
      r_tx_frame <= w_tx_frame_n;
      r_rx_shift <= w_rx_shift_n;
      r_clk_e    <= w_clk_e_n;
      r_data_e   <= w_data_e_n;
      r_tx_done  <= w_tx_done_n;
      r_tx_abort <= w_tx_abort_n;
      r_rx_val   <= w_rx_val_n;
      r_rx_data  <= w_rx_data_n;
      r_rx_err   <= w_rx_err_n;
`ifdef PS2_DEV_RESEND_EN
      r_last_byte <= w_last_byte_n;
      r_last_val  <= w_last_val_n;
`endif
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_phase_n    = (r_phase == '1) ? r_phase : r_phase + 1'b1;
    w_bit_n      = r_bit;
    w_pending_n  = r_pending;
    w_tx_byte_n  = r_tx_byte;
    w_tx_frame_n = r_tx_frame;
    w_rx_shift_n = r_rx_shift;
    w_clk_e_n    = r_clk_e;
    w_data_e_n   = r_data_e;
    w_tx_done_n  = 1'b0;
    w_tx_abort_n = 1'b0;
    w_rx_val_n   = 1'b0;
    w_rx_data_n  = r_rx_data;
    w_rx_err_n   = 1'b0;
`ifdef PS2_DEV_RESEND_EN
    w_last_byte_n = r_last_byte;
    w_last_val_n  = r_last_val;
`endif
    case (r_state)
      S_IDLE: begin
        w_phase_n  = '0;
        w_clk_e_n  = 1'b0;
        w_data_e_n = 1'b0;
        if (r_sclk && !r_sdat) begin
          w_state_n = S_RX_START;
        end else if (r_pending && r_idle_cnt >= I_MAX) begin
          w_state_n    = S_TX_BIT;
          w_bit_n      = '0;
          w_tx_frame_n = {1'b1, ~^r_tx_byte, r_tx_byte};
          w_data_e_n   = 1'b1;
`ifdef PS2_DEV_RESEND_EN
          w_last_byte_n = r_tx_byte;
          w_last_val_n  = 1'b1;
`endif
        end
      end
      S_TX_BIT: begin
        if (r_phase == P_Q) begin
          // host holding clock low while we release it means inhibit
          if (!r_sclk) begin
            w_state_n  = S_WAIT_IDLE;
            w_phase_n  = '0;
            w_clk_e_n  = 1'b0;
            w_data_e_n = 1'b0;
`ifndef PS2_DEV_RESEND_EN
            w_pending_n  = 1'b0;
            w_tx_abort_n = 1'b1;
`endif
          end else begin
            w_clk_e_n = 1'b1;
          end
        end else if (r_phase == P_3Q) begin
          w_clk_e_n = 1'b0;
        end else if (r_phase == P_2H) begin
          w_phase_n = '0;
          if (r_bit == 4'd10) begin
            w_state_n   = S_WAIT_IDLE;
            w_data_e_n  = 1'b0;
            w_pending_n = 1'b0;
            w_tx_done_n = 1'b1;
          end else begin
            w_data_e_n   = ~r_tx_frame[0];
            w_tx_frame_n = {1'b1, r_tx_frame[9:1]};
            w_bit_n      = r_bit + 1'b1;
          end
        end
      end
      S_RX_START: begin
        if (r_phase == P_H) begin
          w_state_n = S_RX_BIT;
          w_phase_n = '0;
          w_bit_n   = '0;
          w_clk_e_n = 1'b1;
        end
      end
      S_RX_BIT: begin
        if (r_phase == P_H) begin
          w_clk_e_n = 1'b0;
        end else if (r_phase == P_S) begin
          w_rx_shift_n = {r_sdat, r_rx_shift[9:1]};
        end else if (r_phase == P_2H) begin
          w_phase_n = '0;
          if (!r_sclk) begin
            w_state_n = S_WAIT_IDLE;
          end else if (r_bit == 4'd9) begin
            if (r_rx_shift[9]) begin
              w_state_n  = S_RX_ACK;
              w_data_e_n = 1'b1;
              w_clk_e_n  = 1'b1;
            end else begin
              w_state_n  = S_WAIT_IDLE;
              w_rx_err_n = 1'b1;
            end
          end else begin
            w_bit_n   = r_bit + 1'b1;
            w_clk_e_n = 1'b1;
          end
        end
      end
      S_RX_ACK: begin
        if (r_phase == P_H) begin
          w_clk_e_n = 1'b0;
        end else if (r_phase == P_2H) begin
          w_state_n  = S_WAIT_IDLE;
          w_phase_n  = '0;
          w_data_e_n = 1'b0;
          if (w_resend_req) begin
`ifdef PS2_DEV_RESEND_EN
            if (!r_pending && r_last_val) begin
              w_pending_n = 1'b1;
              w_tx_byte_n = r_last_byte;
            end
`endif
          end else begin
            w_rx_val_n  = 1'b1;
            w_rx_data_n = r_rx_shift[7:0];
            w_rx_err_n  = !w_par_ok;
          end
        end
      end
      S_WAIT_IDLE: begin
        w_clk_e_n  = 1'b0;
        w_data_e_n = 1'b0;
        if (r_sclk && r_sdat) begin
          if (r_phase >= P_H) begin
            w_state_n = S_IDLE;
            w_phase_n = '0;
          end
        end else begin
          w_phase_n = '0;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
    if (i_tx_val && !r_pending) begin
      w_pending_n = 1'b1;
      w_tx_byte_n = i_tx_data;
    end
  end

  assign o_ps2_clk_e  = r_clk_e;
  assign o_ps2_data_e = r_data_e;
  assign o_tx_ready   = ~r_pending;
  assign o_tx_done    = r_tx_done;
  assign o_tx_abort   = r_tx_abort;
  assign o_rx_val     = r_rx_val;
  assign o_rx_data    = r_rx_data;
  assign o_rx_err     = r_rx_err;

endmodule

// File: tb/tb_ps2_device_port.sv
// tb/tb_ps2_device_port.sv - table-driven bench for ps2_device_port with an open-drain host model
module tb_ps2_device_port;
  localparam int H = 8;
  localparam int I = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       host_clk_e = 1'b0, host_data_e = 1'b0;
  logic       bus_clk, bus_data;
  logic       dut_clk_e, dut_data_e;
  logic       tx_val = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_done, tx_abort, rx_val, rx_err;
  logic [7:0] rx_data;

  assign bus_clk  = ~(dut_clk_e | host_clk_e);
  assign bus_data = ~(dut_data_e | host_data_e);

  ps2_device_port #(.HALF_CYC(H), .IDLE_CYC(I)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ps2_clk(bus_clk), .i_ps2_data(bus_data),
    .o_ps2_clk_e(dut_clk_e), .o_ps2_data_e(dut_data_e),
    .i_tx_val(tx_val), .i_tx_data(tx_data), .o_tx_ready(tx_ready),
    .o_tx_done(tx_done), .o_tx_abort(tx_abort),
    .o_rx_val(rx_val), .o_rx_data(rx_data), .o_rx_err(rx_err)
  );

  int cyc = 0;
  int n_chk = 0, n_pass = 0;
  int n_done = 0, n_abort = 0, n_val = 0, n_err_val = 0, n_err_alone = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_done)           n_done      <= n_done + 1;
    if (tx_abort)          n_abort     <= n_abort + 1;
    if (rx_val)            n_val       <= n_val + 1;
    if (rx_err && rx_val)  n_err_val   <= n_err_val + 1;
    if (rx_err && !rx_val) n_err_alone <= n_err_alone + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic wait_fall(input int budget, output bit found);
    logic prev;
    prev = bus_clk;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (prev && !bus_clk) begin
        found = 1'b1;
        break;
      end
      prev = bus_clk;
    end
  endtask

  task automatic host_rx(output logic [10:0] frame, output int period, output bit ok);
    bit f;
    int t0;
    ok = 1'b1;
    frame = '0;
    period = 0;
    t0 = 0;
    for (int i = 0; i < 11; i++) begin
      wait_fall(400, f);
      if (!f) begin
        ok = 1'b0;
        return;
      end
      frame[i] = bus_data;
      if (i == 0) t0 = cyc;
      if (i == 1) period = cyc - t0;
    end
  endtask

  task automatic offer(input logic [7:0] d);
    @(negedge clk);
    tx_val = 1'b1;
    tx_data = d;
    @(negedge clk);
    tx_val = 1'b0;
  endtask

  task automatic host_tx(input logic [7:0] d, input bit par, input bit stop,
                         input bit with_tx, input logic [7:0] txd,
                         output bit ack, output bit ok);
    bit f;
    logic [9:0] bits;
    bits = {stop, par, d};
    ok = 1'b1;
    ack = 1'b0;
    host_clk_e = 1'b1;
    repeat (10) @(negedge clk);
    host_data_e = 1'b1;
    repeat (4) @(negedge clk);
    host_clk_e = 1'b0;
    if (with_tx) begin
      tx_val = 1'b1;
      tx_data = txd;
    end
    @(negedge clk);
    tx_val = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wait_fall(200, f);
      if (!f) begin
        ok = 1'b0;
        host_data_e = 1'b0;
        return;
      end
      host_data_e = ~bits[i];
    end
    wait_fall(4 * H, f);
    if (f) begin
      repeat (3) @(negedge clk);
      ack = ~bus_data;
    end
    host_data_e = 1'b0;
  endtask

  typedef struct {
    bit         is_tx;
    logic [7:0] data;
    bit         par;
    bit         stop;
    logic [10:0] exp_frame;
    bit         exp_ack;
    int         exp_val;
    int         exp_err;
  } vec_t;

  vec_t        vecs[7];
  logic [10:0] frame;
  int          period;
  bit          ok, ack, f;
  int          d0, a0, v0, ev0, ea0;

  initial begin
    vecs[0] = '{1'b1, 8'h1C, 1'b0, 1'b0, 11'h438, 1'b0, 0, 0};
    vecs[1] = '{1'b1, 8'h00, 1'b0, 1'b0, 11'h600, 1'b0, 0, 0};
    vecs[2] = '{1'b1, 8'hFF, 1'b0, 1'b0, 11'h7FE, 1'b0, 0, 0};
    vecs[3] = '{1'b0, 8'hED, 1'b1, 1'b1, 11'h000, 1'b1, 1, 0};
    vecs[4] = '{1'b0, 8'hED, 1'b0, 1'b1, 11'h000, 1'b1, 1, 1};
    vecs[5] = '{1'b0, 8'h12, 1'b1, 1'b0, 11'h000, 1'b0, 0, 1};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 11'h000, 1'b1, 1, 0};

    repeat (3) @(negedge clk);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_clk_e", dut_clk_e, 0);
    check("rst_data_e", dut_data_e, 0);
    check("rst_tx_done", tx_done, 0);
    check("rst_tx_abort", tx_abort, 0);
    check("rst_rx_val", rx_val, 0);
    check("rst_rx_err", rx_err, 0);
    check("rst_rx_data", rx_data, 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);

    for (int k = 0; k < 7; k++) begin
      if (vecs[k].is_tx) begin
        d0 = n_done;
        offer(vecs[k].data);
        check($sformatf("v%0d_ready_low", k), tx_ready, 0);
        host_rx(frame, period, ok);
        check($sformatf("v%0d_frame_seen", k), ok, 1);
        check($sformatf("v%0d_frame", k), frame, vecs[k].exp_frame);
        check($sformatf("v%0d_period", k), period, 2 * H);
        repeat (60) @(negedge clk);
        check($sformatf("v%0d_done_cnt", k), n_done - d0, 1);
        check($sformatf("v%0d_ready_back", k), tx_ready, 1);
      end else begin
        v0 = n_val; ev0 = n_err_val; ea0 = n_err_alone;
        host_tx(vecs[k].data, vecs[k].par, vecs[k].stop, 1'b0, 8'h00, ack, ok);
        check($sformatf("v%0d_clocks", k), ok, 1);
        check($sformatf("v%0d_ack", k), ack, vecs[k].exp_ack);
        repeat (60) @(negedge clk);
        check($sformatf("v%0d_val_cnt", k), n_val - v0, vecs[k].exp_val);
        check($sformatf("v%0d_err_cnt", k),
              vecs[k].exp_val != 0 ? n_err_val - ev0 : n_err_alone - ea0, vecs[k].exp_err);
        if (vecs[k].exp_val != 0) check($sformatf("v%0d_rx_data", k), rx_data, vecs[k].data);
      end
    end

    // host inhibits during the frame of 0xAA
    a0 = n_abort; d0 = n_done;
    offer(8'hAA);
    f = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_fall(400, f);
      if (!f) break;
    end
    check("inh_falls_seen", f, 1);
    f = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_clk) begin
        f = 1'b1;
        break;
      end
    end
    check("inh_clk_rise", f, 1);
    repeat (2) @(negedge clk);
    host_clk_e = 1'b1;
`ifdef PS2_DEV_RESEND_EN
    repeat (30) @(negedge clk);
    host_clk_e = 1'b0;
    host_rx(frame, period, ok);
    check("resend_seen", ok, 1);
    check("resend_frame", frame, 11'h754);
    repeat (60) @(negedge clk);
    check("resend_abort_cnt", n_abort - a0, 0);
    check("resend_done_cnt", n_done - d0, 1);
    check("resend_ready", tx_ready, 1);
`else
    f = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx_abort) begin
        f = 1'b1;
        check("abort_clk_e", dut_clk_e, 0);
        check("abort_data_e", dut_data_e, 0);
        break;
      end
    end
    check("abort_seen", f, 1);
    repeat (20) @(negedge clk);
    host_clk_e = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_ready", tx_ready, 1);
    check("abort_cnt", n_abort - a0, 1);
    check("abort_done_cnt", n_done - d0, 0);
`endif

    // request-to-send collides with a TX offer: RX goes first
    repeat (30) @(negedge clk);
    v0 = n_val; d0 = n_done;
    host_tx(8'hF4, 1'b0, 1'b1, 1'b1, 8'h55, ack, ok);
    check("coll_clocks", ok, 1);
    check("coll_ack", ack, 1);
    host_rx(frame, period, ok);
    check("coll_tx_seen", ok, 1);
    check("coll_frame", frame, 11'h6AA);
    check("coll_val_cnt", n_val - v0, 1);
    check("coll_rx_data", rx_data, 8'hF4);
    repeat (60) @(negedge clk);
    check("coll_done_cnt", n_done - d0, 1);
    check("coll_ready", tx_ready, 1);

    // reset in the middle of a transmission
    offer(8'h1C);
    f = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_fall(400, f);
      if (!f) break;
    end
    check("mrst_falls_seen", f, 1);
    check("mrst_pre_clk_e", dut_clk_e, 1);
    check("mrst_pre_data_e", dut_data_e, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_clk_e", dut_clk_e, 0);
    check("mrst_data_e", dut_data_e, 0);
    check("mrst_ready", tx_ready, 1);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
